// File: rtl/gobou_mac_ctrl_if.sv
// gobou_mac_ctrl_if: layer handshake plus memory/MAC strobes of the MAC sequencer
interface gobou_mac_ctrl_if #(parameter int LWIDTH = 10, parameter int WWIDTH = 16);
  logic              req;
  logic [LWIDTH-1:0] total_in;
  logic [LWIDTH-1:0] total_out;
  logic              busy;
  logic              ack;
  logic              mem_x_en;
  logic [LWIDTH-1:0] mem_x_addr;
  logic              mem_w_en;
  logic [WWIDTH-1:0] mem_w_addr;
  logic              mac_accum_we;
  logic              mac_out_en;
  logic              mac_reset;
  logic              out_we;
  logic [LWIDTH-1:0] out_addr;
  modport master (output req, total_in, total_out,
                  input busy, ack, mem_x_en, mem_x_addr, mem_w_en, mem_w_addr,
                        mac_accum_we, mac_out_en, mac_reset, out_we, out_addr);
  modport slave  (input req, total_in, total_out,
                  output busy, ack, mem_x_en, mem_x_addr, mem_w_en, mem_w_addr,
                         mac_accum_we, mac_out_en, mac_reset, out_we, out_addr);
endinterface

// File: rtl/gobou_mac_ctrl.sv
// gobou_mac_ctrl: streams x/w reads per neuron and strobes gobou_mac and the output memory
module gobou_mac_ctrl #(
  parameter int LWIDTH  = 10,
  parameter int WWIDTH  = 16,
  parameter int RLAT    = 1,
  parameter int MAC_LAT = 2
) (
  input logic             clk,
  input logic             rst,
  gobou_mac_ctrl_if.slave bus
);
  localparam int D = RLAT + MAC_LAT;
  localparam logic [2:0] IDLE = 3'd0, FEED = 3'd1, DRAIN = 3'd2, OUT = 3'd3, CLR = 3'd4, DONE = 3'd5;
  logic [2:0]        r_state;
  logic [LWIDTH-1:0] r_n, r_m, r_i, r_o;
  logic [WWIDTH-1:0] r_wbase;
  logic [D-1:0]      r_dl;
  logic              w_feed;
  logic [D-1:0]      w_dl_nxt;
  always_comb begin
    w_feed   = r_state == FEED;
    w_dl_nxt = (r_dl << 1) | D'(w_feed);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dl    <= '0;
      r_n     <= '0;
      r_m     <= '0;
      r_i     <= '0;
      r_o     <= '0;
      r_wbase <= '0;
    end else begin
      r_dl <= w_dl_nxt;
      case (r_state)
        IDLE: if (bus.req) begin
          r_n     <= bus.total_in;
          r_m     <= bus.total_out;
          r_i     <= '0;
          r_o     <= '0;
          r_wbase <= '0;
          r_state <= (bus.total_in != '0 && bus.total_out != '0) ? FEED : DONE;
        end
        FEED: begin
          r_i <= r_i + 1'b1;
          if (r_i == r_n - 1'b1) r_state <= DRAIN;
        end
        // leave once the last queued product is consumed this cycle
        DRAIN: if (w_dl_nxt == '0) r_state <= OUT;
        OUT: r_state <= CLR;
        CLR: if (r_o == r_m - 1'b1) r_state <= DONE;
        else begin
          r_o     <= r_o + 1'b1;
          r_wbase <= r_wbase + WWIDTH'(r_n);
          r_i     <= '0;
          r_state <= FEED;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy         = r_state != IDLE;
  assign bus.ack          = r_state == DONE;
  assign bus.mem_x_en     = w_feed;
  assign bus.mem_w_en     = w_feed;
  assign bus.mem_x_addr   = w_feed ? r_i : '0;
  assign bus.mem_w_addr   = w_feed ? r_wbase + WWIDTH'(r_i) : '0;
  assign bus.mac_accum_we = r_dl[D-1];
  assign bus.mac_out_en   = r_state == OUT;
  assign bus.mac_reset    = r_state == CLR;
  assign bus.out_we       = r_state == CLR;
  assign bus.out_addr     = (r_state == CLR) ? r_o : '0;
endmodule

// File: tb/tb_gobou_mac_ctrl.sv
// tb_gobou_mac_ctrl: cycle schedule checked against per-neuron timing arithmetic, plus Q8 end-to-end
module tb_gobou_mac_ctrl;
  localparam int LW = 10, WW = 16, D = 3;
  localparam int OW = 2 + 1 + LW + 1 + WW + 4 + LW;
  logic clk = 0, rst = 1;
  int vecs = 0, errs = 0;
  int xm [16];
  int wm [64];
  int om [16];
  int q [$];
  int acc = 0, y = 0;
  always #5 clk = ~clk;
  gobou_mac_ctrl_if #(.LWIDTH(LW), .WWIDTH(WW)) bus();
  gobou_mac_ctrl #(.LWIDTH(LW), .WWIDTH(WW)) dut(.clk(clk), .rst(rst), .bus(bus));
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc = 0;
    end else begin
      if (bus.mem_x_en) q.push_back((xm[bus.mem_x_addr[3:0]] * wm[bus.mem_w_addr[5:0]]) >>> 8);
      if (bus.mac_accum_we) acc += (q.size() > 0) ? q.pop_front() : 0;
      if (bus.mac_out_en) y = acc;
      if (bus.out_we) om[bus.out_addr[3:0]] = y;
      if (bus.mac_reset) acc = 0;
    end
  end
  function automatic logic [OW-1:0] obs(input bit mask);
    logic [LW-1:0] xa, oa;
    logic [WW-1:0] wa;
    xa = (mask && !bus.mem_x_en) ? '0 : bus.mem_x_addr;
    wa = (mask && !bus.mem_w_en) ? '0 : bus.mem_w_addr;
    oa = (mask && !bus.out_we) ? '0 : bus.out_addr;
    return {bus.busy, bus.ack, bus.mem_x_en, xa, bus.mem_w_en, wa,
            bus.mac_accum_we, bus.mac_out_en, bus.mac_reset, bus.out_we, oa};
  endfunction
  function automatic int ack_time(input int n, input int m);
    return (n == 0 || m == 0) ? 1 : 1 + m * (n + D + 2);
  endfunction
  function automatic logic [OW-1:0] expv(input int n, input int m, input int t);
    logic en = 0, awe = 0, oe = 0, cl = 0;
    int xa = 0, wa = 0, oa = 0, f;
    int at = ack_time(n, m);
    if (n > 0 && m > 0)
      for (int k = 0; k < m; k++) begin
        f = 1 + k * (n + D + 2);
        if (t >= f && t < f + n) begin en = 1; xa = t - f; wa = k * n + t - f; end
        if (t >= f + D && t < f + n + D) awe = 1;
        if (t == f + n + D) oe = 1;
        if (t == f + n + D + 1) begin cl = 1; oa = k; end
      end
    return {(t >= 1 && t <= at), (t == at), en, LW'(xa), en, WW'(wa), awe, oe, cl, cl, LW'(oa)};
  endfunction
  task automatic check(input string tag, input int t, input logic [OW-1:0] o, input logic [OW-1:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, e);
    end
  endtask
  task automatic run(input int n, input int m, input bit noise);
    int at = ack_time(n, m);
    @(posedge clk); #1;
    bus.req = 1; bus.total_in = LW'(n); bus.total_out = LW'(m);
    for (int t = 1; t <= at + 2; t++) begin
      @(posedge clk); #1;
      bus.req = noise && t < at ? 1'($urandom) : 1'b0;
      if (noise) begin bus.total_in = LW'($urandom); bus.total_out = LW'($urandom); end
      check($sformatf("run n=%0d m=%0d", n, m), t, obs(1), expv(n, m, t));
    end
    bus.req = 0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin xm[i] = 0; om[i] = 0; end
    for (int i = 0; i < 64; i++) wm[i] = 0;
    xm[0] = 256; xm[1] = 512; xm[2] = 768;
    wm[0] = 256; wm[1] = 256; wm[2] = 256; wm[3] = 512; wm[4] = 0; wm[5] = 256;
    bus.req = 0; bus.total_in = 4; bus.total_out = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset", i, obs(0), '0);
      bus.req = ~bus.req;
    end
    bus.req = 0; rst = 0;
    run(4, 1, 0);
    run(3, 2, 0);
    vecs++;
    assert (om[0] === 1536) else begin errs++; $error("FAIL e2e_y0 observed=%0d expected=1536", om[0]); end
    vecs++;
    assert (om[1] === 1280) else begin errs++; $error("FAIL e2e_y1 observed=%0d expected=1280", om[1]); end
    run(0, 5, 0);
    run(5, 0, 0);
    run(2, 3, 1);
    @(posedge clk); #1;
    bus.req = 1; bus.total_in = 4; bus.total_out = 1;
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk); #1;
      bus.req = 0;
      check("pre_abort", t, obs(1), expv(4, 1, t));
    end
    rst = 1;
    @(posedge clk); #1;
    check("abort", 4, obs(0), '0);
    rst = 0;
    for (int t = 5; t <= 12; t++) begin
      @(posedge clk); #1;
      check("post_abort_idle", t, obs(0), '0);
    end
    run(4, 1, 0);
    repeat (8) run($urandom_range(1, 6), $urandom_range(1, 4), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/gobou_mac_ctrl.md
Name: gobou_mac_ctrl

Overview:
Sequencer that drives gobou_mac from the initiator side of the MAC control interface.
- For each output neuron it streams input/weight read addresses to the x and w memories.
- It generates accum_we/out_en/reset for the MAC, aligned to the memory read latency and the MAC pipeline latency.
- It strobes the write of y into the output memory.
- Sits between the gobou layer controller (req/ack) and the gobou_mac + on-chip memories.

Parameters:
- LWIDTH, 10, width of total_in/total_out and of the input/output address counters.
- WWIDTH, 16, width of weight memory address.
- RLAT, 1, read latency of x/w memories (address cycle to data at MAC input).
- MAC_LAT, 2, cycles from operands at MAC input to the accum_we cycle that consumes their product.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req, in, 1, start pulse; sampled only in IDLE.
- total_in, in, LWIDTH, inputs per neuron (n).
- total_out, in, LWIDTH, number of neurons (m).
- busy, out, 1, high from the cycle after an accepted req until the ack cycle inclusive.
- ack, out, 1, one-cycle completion pulse.
- mem_x_en, out, 1, x memory read enable.
- mem_x_addr, out, LWIDTH, x read address.
- mem_w_en, out, 1, w memory read enable.
- mem_w_addr, out, WWIDTH, w read address.
- mac_accum_we, out, 1, to gobou_mac accum_we.
- mac_out_en, out, 1, to gobou_mac out_en.
- mac_reset, out, 1, to gobou_mac reset.
- out_we, out, 1, output memory write enable; data is gobou_mac y.
- out_addr, out, LWIDTH, output memory address (neuron index).

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, delay line cleared. rst mid-operation aborts the run: next cycle all outputs 0, no ack, state IDLE.
- D = RLAT + MAC_LAT (default 3).
- States: IDLE -> FEED -> DRAIN -> OUT -> CLR -> (FEED | DONE) -> IDLE.
- IDLE: if req=1, total_in≥1 and total_out≥1, latch n and m, clear i, o and wbase, go to FEED. If req=1 with n=0 or m=0, go to DONE with no memory or MAC activity.
- FEED (exactly n cycles):
  - mem_x_en = mem_w_en = 1.
  - mem_x_addr = i; mem_w_addr = wbase + i. No multiplier: wbase accumulates n per neuron.
  - i increments each cycle; at i = n-1 go to DRAIN.
- Delay line: a feed-valid bit is shifted D stages; mac_accum_we equals the delayed bit. mac_accum_we is therefore high for exactly n cycles, starting D cycles after the first mem_en.
- DRAIN: wait until the delay line is empty. The cycle after the last mac_accum_we is OUT.
- OUT: mac_out_en = 1 for one cycle.
- CLR (one cycle):
  - out_we = 1, out_addr = o; y is valid this cycle.
  - mac_reset = 1.
  - If o = m-1 go to DONE; else o++, wbase += n, i = 0, go to FEED.
- DONE: ack = 1 for one cycle, then IDLE.
- Timing per neuron, with first FEED cycle F:
  - mem_en at F..F+n-1.
  - mac_accum_we at F+D..F+n-1+D.
  - mac_out_en at F+n+D.
  - out_we/mac_reset at F+n+D+1.
  - Next F = F+n+D+2.
- mac_reset is never asserted in the same cycle as mac_accum_we or mac_out_en.
- req while busy is ignored.
- total_in/total_out changes after acceptance have no effect.
- Counters do not wrap inside a run. n·m ≤ 2^WWIDTH is a caller guarantee.

Test Plan:
- Reset: hold rst 3 cycles with req toggling -> every output 0 throughout; busy=0.
- Single neuron, n=4, m=1, req sampled at cycle 0 (defaults):
  - mem_en cycles 1–4, x/w addr 0,1,2,3.
  - mac_accum_we cycles 4–7.
  - mac_out_en cycle 8.
  - out_we+mac_reset cycle 9 with out_addr=0.
  - ack cycle 10.
- Two neurons, n=3, m=2:
  - w addr 0,1,2 (cycles 1–3), then 3,4,5 (cycles 9–11); x addr 0,1,2 in both passes.
  - out_we cycle 8 addr 0 and cycle 16 addr 1.
  - ack cycle 17.
- End-to-end with gobou_mac and behavioural memories, Q8 data (x=[1,2,3]·256, w=[1,1,1,2,0,1]·256, n=3, m=2) -> output memory[0]=1536, [1]=1280.
- Degenerate and abort:
  - req with n=0 -> ack at cycle 1, no mem_en, no MAC strobes.
  - req during busy -> ignored, schedule unchanged.
- Reset mid-run: rst at cycle 3 of the n=4 run -> cycle 4 all outputs 0, no ack. A fresh req then reproduces the single-neuron timing exactly.
